mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage load/store engine. It consumes the memory control fields produced at decode (MemRW and RWType) together with the EX-stage address and store data, and drives a req/ack data-memory bus. It performs store byte-lane alignment with write masks and load lane extraction with sign or zero extension. It stalls the pipeline until the access completes, and flags misaligned accesses, illegal widths and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, REQ-state cycles to wait for bus_ack before aborting; 0 disables the timeout
ADDR_W, 32, address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage holds a valid instruction
is_load  in  1  instruction is a load (MemtoReg = MEM)
is_store  in  1  instruction is a store (MemRW = WRITE)
rw_type  in  3  fun3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  ADDR_W  effective address from the ALU
store_data  in  32  rs2 value
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_wmask  out  4  byte write enables
bus_wdata  out  32  lane-replicated write data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  bus completion
stall  out  1  freeze IF/ID/EX/MEM registers
done  out  1  one-cycle access completion pulse
load_data  out  32  extended load result, valid while done=1
misaligned  out  1  fault: misaligned address or illegal rw_type, valid with done
timeout  out  1  fault: bus did not ack, valid with done

Behaviour:
- Reset: state IDLE. All registered outputs are 0: bus_req, bus_we, bus_addr, bus_wmask, bus_wdata, done, load_data, misaligned, timeout. stall=0.
- A request exists when req_valid && (is_load || is_store). If both is_load and is_store are set, the access is a store.
- IDLE, request present:
  - If rw_type is 011, 110 or 111, or the address is misaligned (H/HU with addr[0]=1, W with addr[1:0]≠0), go to FAULT.
  - Otherwise latch the request and go to REQ. bus_req=1 from the next cycle onward.
- stall is combinational: (IDLE && request present) || REQ || FAULT. stall=0 in DONE so the pipeline advances exactly on the done cycle.
- REQ:
  - bus_req, bus_we, bus_addr, bus_wmask and bus_wdata are held stable until bus_ack.
  - bus_ack is honoured in any REQ cycle, including the first.
  - On ack: drop bus_req next cycle and go to DONE. For a load, capture the extracted bus_rdata into load_data.
- Timeout: a counter clears on REQ entry and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, drop bus_req, set timeout=1 and go to DONE. An ack arriving in the same cycle the count hits the limit wins: normal completion, no timeout.
- FAULT: lasts 1 cycle with no bus activity, then DONE with misaligned=1.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - misaligned, timeout and load_data hold their values only while done=1, and are 0 otherwise.
  - req_valid is ignored in DONE; the next instruction is sampled in IDLE on the following cycle.
- Store formatting:
  - SB: wdata={4{sd[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wmask=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=sd, wmask=4'b1111.
- Loads drive wmask=0 and bus_we=0.
- Load extraction: lane = bus_rdata >> (8*addr[1:0]).
  - B and H are sign-extended from bit 7 and bit 15 respectively.
  - BU and HU are zero-extended.
  - W passes bus_rdata through unchanged.
- Back-to-back accesses: minimum 3 cycles each (IDLE, REQ with immediate ack, DONE).
- Reset asserted mid-access aborts it: bus_req=0 after that edge, and no done pulse is produced. A bus_ack arriving after reset is ignored.

Test Plan:
- SW addr=0x100, sd=0xDEADBEEF, ack on the first REQ cycle → bus_we=1, bus_addr=0x100, wmask=1111, wdata=0xDEADBEEF; done exactly 2 cycles after the request; stall high for 2 cycles.
- SB addr=0x103, sd=0x000000A5 → wmask=1000, wdata=0xA5A5A5A5. SH addr=0x102, sd=0x1234 → wmask=1100, wdata=0x12341234.
- LB addr=0x201, rdata=0x00008000 → load_data=0xFFFFFF80. LBU same → 0x00000080. LH addr=0x202, rdata=0x80010000 → 0xFFFF8001. LHU → 0x00008001.
- LW addr=0x102 → no bus_req, done with misaligned=1 after 2 cycles. rw_type=011 → same result.
- Ack withheld, TIMEOUT_CYCLES=4 → bus_req high 4 cycles then drops, done with timeout=1. Ack on the 4th cycle → normal done, timeout=0.
- rst asserted 2 cycles into REQ → bus_req=0 and stall=0 next cycle, no done; a later stray ack has no effect and a new LW completes normally.

Source files
------------

// File: rtl/mem_bus_if.sv
// mem_bus_if: req/ack data-memory bus between the MEM stage and memory.
// The master holds its request fields stable until the ack.
interface mem_bus_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wmask;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wmask,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wmask,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine on a req/ack data bus.
// Aligns stores, extends loads, stalls the pipe and flags faults.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        rw_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    mem_bus_if.master         bus,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FAULT,
        DONE
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       rw_q;
    logic [1:0]       off_q;

    logic        req_present;
    logic        store_sel;
    logic        bad_type;
    logic        bad_align;
    logic        fault_in;
    logic        start;
    logic        tmo_hit;
    logic        tmo_fire;
    logic        ld_cap;
    logic [3:0]  wmask_nx;
    logic [31:0] wdata_nx;
    logic [31:0] lane;
    logic [31:0] ld_ext;

    assign req_present = req_valid && (is_load || is_store);
    assign store_sel   = is_store;
    assign bad_type    = (rw_type == 3'b011) ||
                         (rw_type == 3'b110) ||
                         (rw_type == 3'b111);

    always_comb begin
        bad_align = 1'b0;
        unique case (rw_type)
            3'b001,
            3'b101:  bad_align = addr[0];
            3'b010:  bad_align = (addr[1:0] != 2'b00);
            default: bad_align = 1'b0;
        endcase
    end

    assign fault_in = bad_type || bad_align;
    assign start    = (state == IDLE) && req_present && !fault_in;
    // A zero limit disables the watchdog; an ack in the limit cycle wins.
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);
    assign tmo_fire = (state == REQ) && !bus.bus_ack && tmo_hit;
    assign ld_cap   = (state == REQ) && bus.bus_ack && !bus.bus_we;

    always_comb begin
        wmask_nx = 4'b0000;
        wdata_nx = 32'h0;
        if (store_sel) begin
            unique case (1'b1)
                (rw_type[1:0] == 2'b10): begin
                    wmask_nx = 4'b1111;
                    wdata_nx = store_data;
                end
                (rw_type[1:0] == 2'b01): begin
                    wmask_nx = 4'b0011 << {addr[1], 1'b0};
                    wdata_nx = {2{store_data[15:0]}};
                end
                default: begin
                    wmask_nx = 4'b0001 << addr[1:0];
                    wdata_nx = {4{store_data[7:0]}};
                end
            endcase
        end
    end

    assign lane = bus.bus_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = lane;
        unique case (rw_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_present) begin
                    stall    = 1'b1;
                    state_nx = fault_in ? FAULT : REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_ack || tmo_hit) state_nx = DONE;
            end
            FAULT: begin
                stall    = 1'b1;
                state_nx = DONE;
            end
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wmask <= 4'b0000;
            bus.bus_wdata <= 32'h0;
            done          <= 1'b0;
            load_data     <= 32'h0;
            misaligned    <= 1'b0;
            timeout       <= 1'b0;
            cnt           <= '0;
            rw_q          <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            // Result flags live only for the single DONE cycle.
            done       <= (state_nx == DONE);
            misaligned <= (state == FAULT);
            timeout    <= tmo_fire;
            load_data  <= ld_cap ? ld_ext : 32'h0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= store_sel;
                        bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus.bus_wmask <= wmask_nx;
                        bus.bus_wdata <= wdata_nx;
                        rw_q          <= rw_type;
                        off_q         <= addr[1:0];
                        cnt           <= '0;
                    end
                end
                REQ: begin
                    if (bus.bus_ack || tmo_hit) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= '0;
                        bus.bus_wmask <= 4'b0000;
                        bus.bus_wdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store accesses checked
// against an arithmetic model of alignment, extension and fault rules.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  rw_type;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        timeout;

    int n_chk;
    int n_fail;

    mem_bus_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES(TMO),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .is_load(is_load),
        .is_store(is_store),
        .rw_type(rw_type),
        .addr(addr),
        .store_data(store_data),
        .bus(bus),
        .stall(stall),
        .done(done),
        .load_data(load_data),
        .misaligned(misaligned),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] t);
        case (t[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_bad(input logic [2:0] t,
                                  input logic [31:0] a);
        int unsigned sz;
        if (t == 3'd3 || t == 3'd6 || t == 3'd7) return 1'b1;
        sz = size_of(t);
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t,
                                           input logic [31:0] sd);
        case (size_of(t))
            1:       return (sd & 32'hFF) * 32'h01010101;
            2:       return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] m_wmask(input logic [2:0] t,
                                          input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (size_of(t))
            1:       return 4'(1 << off);
            2:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t,
                                          input logic [31:0] a,
                                          input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (t)
            3'd0: begin
                v = v & 32'hFF;
                return (v >= 128) ? v - 256 : v;
            end
            3'd4: return v & 32'hFF;
            3'd1: begin
                v = v & 32'hFFFF;
                return (v >= 32768) ? v - 65536 : v;
            end
            3'd5: return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge idle.
    task automatic access(input bit st, input bit ld,
                          input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int ack_at);
        bit          bad;
        bit          timed;
        int          eff;
        logic [31:0] exp_ld;
        req_valid  = 1'b1;
        is_load    = ld;
        is_store   = st;
        rw_type    = t;
        addr       = a;
        store_data = sd;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        #1;
        chk("stall_req", stall, 1);
        @(negedge clk);
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        bad   = is_bad(t, a);
        timed = !(ack_at >= 1 && ack_at <= TMO);
        if (bad) begin
            chk("fault_noreq", bus.bus_req, 0);
            chk("fault_stall", stall, 1);
            chk("fault_nodone", done, 0);
            @(negedge clk);
        end else begin
            eff = timed ? TMO : ack_at;
            for (int k = 1; k <= eff; k++) begin
                chk("req_hi", bus.bus_req, 1);
                chk("req_stall", stall, 1);
                chk("req_we", bus.bus_we, st);
                chk("req_addr", bus.bus_addr, {a[31:2], 2'b00});
                chk("req_wmask", bus.bus_wmask,
                    st ? m_wmask(t, a) : 4'h0);
                if (st) chk("req_wdata", bus.bus_wdata, m_wdata(t, sd));
                if (k == ack_at) begin
                    bus.bus_ack   = 1'b1;
                    bus.bus_rdata = rd;
                end
                @(negedge clk);
                bus.bus_ack   = 1'b0;
                bus.bus_rdata = $urandom;
            end
        end
        exp_ld = (!bad && !timed && !st) ? m_load(t, a, rd) : 32'h0;
        chk("done_hi", done, 1);
        chk("done_stall", stall, 0);
        chk("done_noreq", bus.bus_req, 0);
        chk("done_misal", misaligned, bad);
        chk("done_tmo", timeout, !bad && timed);
        chk("done_ldata", load_data, exp_ld);
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_misal", misaligned, 0);
        chk("idle_tmo", timeout, 0);
        chk("idle_ldata", load_data, 0);
    endtask

    initial begin
        bit          st;
        bit          ld;
        logic [2:0]  t;
        logic [31:0] a;
        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        req_valid     = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        rw_type       = 3'b000;
        addr          = 32'h0;
        store_data    = 32'h0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", bus.bus_req, 0);
        chk("rst_we", bus.bus_we, 0);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_wmask", bus.bus_wmask, 0);
        chk("rst_wdata", bus.bus_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flags", {misaligned, timeout}, 0);

        access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        access(1, 0, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        access(1, 0, 3'b001, 32'h102, 32'h00001234, 32'h0, 2);
        access(1, 1, 3'b010, 32'h104, 32'h0BADF00D, 32'h0, 1);
        access(0, 1, 3'b000, 32'h201, 32'h0, 32'h00008000, 1);
        access(0, 1, 3'b100, 32'h201, 32'h0, 32'h00008000, 1);
        access(0, 1, 3'b001, 32'h202, 32'h0, 32'h80010000, 1);
        access(0, 1, 3'b101, 32'h202, 32'h0, 32'h80010000, 3);
        access(0, 1, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 2);
        access(0, 1, 3'b010, 32'h102, 32'h0, 32'h0, 1);
        access(0, 1, 3'b011, 32'h100, 32'h0, 32'h0, 1);
        access(1, 0, 3'b001, 32'h101, 32'h1, 32'h0, 1);
        access(0, 1, 3'b010, 32'h400, 32'h0, 32'h12345678, 0);
        access(0, 1, 3'b010, 32'h400, 32'h0, 32'h12345678, 4);

        // Reset two cycles into REQ, then a stray ack.
        req_valid = 1'b1;
        is_load   = 1'b1;
        rw_type   = 3'b010;
        addr      = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        is_load   = 1'b0;
        chk("rr_req1", bus.bus_req, 1);
        @(negedge clk);
        chk("rr_req2", bus.bus_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_noreq", bus.bus_req, 0);
        chk("rr_nostall", stall, 0);
        chk("rr_nodone", done, 0);
        rst = 1'b0;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stray_done", done, 0);
        chk("stray_req", bus.bus_req, 0);
        bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_done2", done, 0);
        chk("stray_ldata", load_data, 0);
        access(0, 1, 3'b010, 32'h300, 32'h0, 32'h55AA33CC, 1);

        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom);
            ld = 1'($urandom);
            if (!st && !ld) ld = 1'b1;
            t = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a = a & ~32'((size_of(t) == 0) ? 0 : size_of(t) - 1);
            end
            access(st, ld, t, a, $urandom, $urandom,
                   int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
